// File: rtl/spi_master_fsm.sv
// SPI mode-0 master that sends a 16-bit command word plus a 16-bit data word to one of N_SLAVES
// chip-selected slaves and captures the slave's reply during the data word.
module spi_master_fsm #(
    parameter int N_SLAVES = 4,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_IDLE  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                rd,
    input  logic [2:0]          slave_sel,
    input  logic [7:0]          addr,
    input  logic [15:0]         wdata,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [15:0]         rdata,
    output logic                sclk,
    output logic                mosi,
    input  logic                miso,
    output logic [N_SLAVES-1:0] cs_n
);

    localparam int CW = 16;

    generate
        if (CLK_DIV < 4 || CS_SETUP < 4 || CS_HOLD < 4 || CS_IDLE < 4 ||
            N_SLAVES < 1 || N_SLAVES > 8) begin : g_bad_param
            $error("spi_master_fsm: illegal parameter value");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t              state_reg, state_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [5:0]          half_reg, half_next;
    logic [31:0]         frame_reg, frame_next;
    logic [15:0]         cap_reg, cap_next;
    logic [15:0]         rdata_reg, rdata_next;
    logic                rd_reg, rd_next;
    logic                sclk_reg, sclk_next;
    logic                mosi_reg, mosi_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;
    logic [N_SLAVES-1:0] cs_n_reg, cs_n_next;
    logic [N_SLAVES-1:0] sel_hot;
    logic                sel_valid;
    logic [31:0]         new_frame;

    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_dec
        assign sel_hot[gi] = (slave_sel == 3'(gi));
    end

    assign sel_valid = int'(slave_sel) < N_SLAVES;
    assign new_frame = {2'b00, slave_sel, addr, 1'b0, rd, 1'b0, rd ? 16'h0000 : wdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            half_reg  <= '0;
            frame_reg <= '0;
            cap_reg   <= '0;
            rdata_reg <= '0;
            rd_reg    <= 1'b0;
            sclk_reg  <= 1'b0;
            mosi_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            cs_n_reg  <= '1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            half_reg  <= half_next;
            frame_reg <= frame_next;
            cap_reg   <= cap_next;
            rdata_reg <= rdata_next;
            rd_reg    <= rd_next;
            sclk_reg  <= sclk_next;
            mosi_reg  <= mosi_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            cs_n_reg  <= cs_n_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        half_next  = half_reg;
        frame_next = frame_reg;
        cap_next   = cap_reg;
        rdata_next = rdata_reg;
        rd_next    = rd_reg;
        sclk_next  = sclk_reg;
        mosi_next  = mosi_reg;
        busy_next  = busy_reg;
        cs_n_next  = cs_n_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (sel_valid) begin
                        state_next = SETUP;
                        cnt_next   = '0;
                        busy_next  = 1'b1;
                        rd_next    = rd;
                        frame_next = new_frame;
                        mosi_next  = new_frame[31];
                        cs_n_next  = ~sel_hot;
                    end else begin
                        done_next = 1'b1;
                        err_next  = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (cnt_reg == CW'(CS_SETUP - 1)) begin
                    // The first rising edge is launched on entry to SHIFT.
                    state_next = SHIFT;
                    cnt_next   = '0;
                    half_next  = '0;
                    sclk_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_reg == CW'(CLK_DIV - 1)) begin
                    cnt_next  = '0;
                    half_next = half_reg + 1'b1;
                    if (half_reg == 6'd63) begin
                        state_next = HOLD;
                        sclk_next  = 1'b0;
                        mosi_next  = 1'b0;
                    end else if (sclk_reg) begin
                        sclk_next  = 1'b0;
                        frame_next = {frame_reg[30:0], 1'b0};
                        mosi_next  = frame_reg[30];
                    end else begin
                        sclk_next = 1'b1;
                        // Only rising edges 17..32 carry the slave's data word.
                        if (half_reg >= 6'd31) begin
                            cap_next = {cap_reg[14:0], miso};
                        end
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_reg == CW'(CS_HOLD - 1)) begin
                    state_next = GAP;
                    cnt_next   = '0;
                    cs_n_next  = '1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            GAP: begin
                if (cnt_reg == CW'(CS_IDLE - 1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    if (rd_reg) begin
                        rdata_next = cap_reg;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy  = busy_reg;
    assign done  = done_reg;
    assign err   = err_reg;
    assign rdata = rdata_reg;
    assign sclk  = sclk_reg;
    assign mosi  = mosi_reg;
    assign cs_n  = cs_n_reg;

endmodule

// File: tb/tb_spi_master_fsm.sv
// Bench for spi_master_fsm: behavioural SPI slaves with per-slave RAM, a bus monitor, directed
// vectors, a start-while-busy and mid-transfer reset sequence, and randomized traffic.
module tb_spi_master_fsm;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        rd;
    logic [2:0]  slave_sel;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] rdata;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic [3:0]  cs_n;

    int checks;
    int errors;

    spi_master_fsm #(
        .N_SLAVES(4), .CLK_DIV(4), .CS_SETUP(4), .CS_HOLD(4), .CS_IDLE(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rd(rd), .slave_sel(slave_sel),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave models and bus monitor, evaluated mid-cycle.
    logic [15:0] slave_ram [4][256];
    int          rise_total;
    int          viol;
    int          cs_low_cnt [4];
    logic [31:0] mosi_hist;

    initial begin
        int          bit_cnt;
        int          n_low;
        int          act;
        logic [31:0] rx;
        logic [15:0] rd_word;
        logic        sclk_prev;
        logic        mosi_prev;
        for (int s = 0; s < 4; s++) begin
            cs_low_cnt[s] = 0;
            for (int a = 0; a < 256; a++) slave_ram[s][a] = 16'h0000;
        end
        rise_total = 0; viol = 0; mosi_hist = '0; miso = 1'b0;
        bit_cnt = 0; rx = '0; rd_word = '0; act = 0; sclk_prev = 1'b0; mosi_prev = 1'b0;
        forever begin
            @(negedge clk);
            n_low = 0;
            for (int i = 0; i < 4; i++) begin
                if (!cs_n[i]) begin
                    n_low++;
                    cs_low_cnt[i]++;
                    act = i;
                end
            end
            if (n_low > 1) viol++;
            if (sclk && (mosi !== mosi_prev)) viol++;
            if (n_low == 0) begin
                if (sclk || mosi) viol++;
                bit_cnt = 0;
                miso    = 1'b0;
            end else begin
                if (sclk && !sclk_prev) begin
                    rx        = {rx[30:0], mosi};
                    mosi_hist = {mosi_hist[30:0], mosi};
                    bit_cnt++;
                    rise_total++;
                    if (bit_cnt == 16)
                        rd_word = (rx[13:11] == 3'(act)) ? slave_ram[act][rx[10:3]] : 16'hDEAD;
                    if (bit_cnt == 32 && !rx[17] && rx[29:27] == 3'(act))
                        slave_ram[act][rx[26:19]] = rx[15:0];
                end
                if (!sclk && sclk_prev) begin
                    if (bit_cnt >= 16 && bit_cnt < 32) miso = rd_word[5'(31 - bit_cnt)];
                    else miso = 1'($urandom);
                end
            end
            sclk_prev = sclk;
            mosi_prev = mosi;
        end
    end

    // Reference state: what each slave should hold, and the last read word.
    logic [15:0] ref_ram [4][256];
    logic [15:0] cur_rdata;
    int          tn;

    function automatic logic [31:0] ref_frame(input logic f_rd, input logic [2:0] f_sel,
                                              input logic [7:0] f_addr, input logic [15:0] f_wd);
        logic [15:0] cmd;
        cmd = 16'(f_sel) * 16'd2048 + 16'(f_addr) * 16'd8 + (f_rd ? 16'd2 : 16'd0);
        return {cmd, f_rd ? 16'h0000 : f_wd};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exec(input logic t_rd, input logic [2:0] t_sel, input logic [7:0] t_addr,
                        input logic [15:0] t_wd, input logic exp_err, input logic [31:0] exp_frame,
                        input logic [3:0] exp_cs, input logic [15:0] exp_rdata, input int poke_at);
        int          r0, v0, cyc;
        int          c0 [4];
        logic        busy1;
        logic [3:0]  cs_pat;
        r0 = rise_total; v0 = viol;
        for (int i = 0; i < 4; i++) c0[i] = cs_low_cnt[i];
        @(posedge clk); #1;
        rd = t_rd; slave_sel = t_sel; addr = t_addr; wdata = t_wd; start = 1'b1;
        cyc = -1; busy1 = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (n == 1) begin
                busy1 = busy;
                rd = 1'($urandom); slave_sel = 3'($urandom); addr = 8'($urandom); wdata = 16'($urandom);
            end
            if (poke_at != 0 && n == poke_at) start = 1'b1;
            if (done) begin
                cyc = n;
                break;
            end
        end
        for (int i = 0; i < 4; i++) cs_pat[i] = (cs_low_cnt[i] == c0[i]);
        tn++;
        $display("txn %0d rd=%0b sel=%0d addr=%02h wdata=%04h -> cycles=%0d err=%0b rdata=%04h frame=%08h",
                 tn, t_rd, t_sel, t_addr, t_wd, cyc, err, rdata, mosi_hist);
        chk($sformatf("txn%0d cycles", tn), cyc, exp_err ? 1 : 269);
        chk($sformatf("txn%0d err", tn), {31'b0, err}, {31'b0, exp_err});
        chk($sformatf("txn%0d rdata", tn), {16'b0, rdata}, {16'b0, exp_rdata});
        chk($sformatf("txn%0d busy", tn), {31'b0, busy1}, {31'b0, !exp_err});
        chk($sformatf("txn%0d cs_n", tn), {28'b0, cs_pat}, {28'b0, exp_cs});
        chk($sformatf("txn%0d sclk_rises", tn), rise_total - r0, exp_err ? 0 : 32);
        chk($sformatf("txn%0d bus_rules", tn), viol - v0, 0);
        if (!exp_err) chk($sformatf("txn%0d frame", tn), mosi_hist, exp_frame);
        if (!exp_err && t_rd) cur_rdata = exp_rdata;
        if (!exp_err && !t_rd) ref_ram[t_sel][t_addr] = t_wd;
    endtask

    typedef struct {
        logic        rd;
        logic [2:0]  sel;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic        exp_err;
        logic [31:0] exp_frame;
        logic [3:0]  exp_cs;
        logic [15:0] exp_rdata;
    } vec_t;

    initial begin
        vec_t        vecs [7];
        logic        r_rd;
        logic [2:0]  r_sel;
        logic [7:0]  r_addr;
        logic [15:0] r_wd;
        logic        r_err;
        int          busy_seen;
        int          r0;

        checks = 0; errors = 0; tn = 0; cur_rdata = 16'h0000;
        for (int s = 0; s < 4; s++)
            for (int a = 0; a < 256; a++) ref_ram[s][a] = 16'h0000;

        vecs[0] = '{1'b0, 3'd0, 8'h12, 16'hA5C3, 1'b0, 32'h0090A5C3, 4'b1110, 16'h0000};
        vecs[1] = '{1'b1, 3'd0, 8'h12, 16'h5555, 1'b0, 32'h00920000, 4'b1110, 16'hA5C3};
        vecs[2] = '{1'b0, 3'd2, 8'hFF, 16'h0001, 1'b0, 32'h17F80001, 4'b1011, 16'hA5C3};
        vecs[3] = '{1'b0, 3'd5, 8'h33, 16'h1111, 1'b1, 32'h00000000, 4'b1111, 16'hA5C3};
        vecs[4] = '{1'b0, 3'd3, 8'h40, 16'hBEEF, 1'b0, 32'h1A00BEEF, 4'b0111, 16'hA5C3};
        vecs[5] = '{1'b1, 3'd3, 8'h40, 16'h0000, 1'b0, 32'h1A020000, 4'b0111, 16'hBEEF};
        vecs[6] = '{1'b1, 3'd2, 8'hFF, 16'hFFFF, 1'b0, 32'h17FA0000, 4'b1011, 16'h0001};

        rst_n = 1'b0; start = 1'b0; rd = 1'b0; slave_sel = 3'd0; addr = 8'h00; wdata = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset cs_n", {28'b0, cs_n}, 32'hF);
        chk("reset outputs", {busy, done, err, sclk, mosi, rdata}, 21'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            exec(vecs[i].rd, vecs[i].sel, vecs[i].addr, vecs[i].wdata, vecs[i].exp_err,
                 vecs[i].exp_frame, vecs[i].exp_cs, vecs[i].exp_rdata, 0);
            if (i == 0) chk("slave ram[0][12]", {16'b0, slave_ram[0][8'h12]}, 32'hA5C3);
        end

        // A start pulse while busy must not launch a second transaction.
        exec(1'b0, 3'd1, 8'h33, 16'h1234, 1'b0, 32'h09981234, 4'b1101, cur_rdata, 20);
        busy_seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (busy || cs_n != 4'hF) busy_seen++;
        end
        chk("no accept of start while busy", busy_seen, 0);

        // Reset at the 10th SCLK rising edge of a write.
        r0 = rise_total;
        @(posedge clk); #1;
        rd = 1'b0; slave_sel = 3'd1; addr = 8'h44; wdata = 16'h7777; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 400 && rise_total - r0 < 10; n++) begin
            @(posedge clk); #1;
        end
        chk("reached sclk edge 10", rise_total - r0, 10);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset cs_n", {28'b0, cs_n}, 32'hF);
        chk("async reset busy/sclk/mosi/done", {28'b0, busy, sclk, mosi, done}, 32'h0);
        chk("async reset rdata", {16'b0, rdata}, 32'h0);
        cur_rdata = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exec(1'b0, 3'd1, 8'h44, 16'h7777, 1'b0, 32'h0A207777, 4'b1101, 16'h0000, 0);
        exec(1'b1, 3'd1, 8'h44, 16'h0000, 1'b0, 32'h0A220000, 4'b1101, 16'h7777, 0);

        // Randomized traffic against the reference state.
        for (int k = 0; k < 24; k++) begin
            r_rd   = 1'($urandom);
            r_sel  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            r_addr = 8'h20 + 8'($urandom_range(0, 3));
            r_wd   = 16'($urandom);
            r_err  = (r_sel >= 3'd4);
            exec(r_rd, r_sel, r_addr, r_wd, r_err, ref_frame(r_rd, r_sel, r_addr, r_wd),
                 r_err ? 4'hF : ~(4'b0001 << r_sel),
                 (!r_err && r_rd) ? ref_ram[r_sel[1:0]][r_addr] : cur_rdata, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_fsm.md
SPI_MASTER_FSM -- requirements
Module: spi_master_fsm

Interface
REQ-001 SHALL provide parameter N_SLAVES, default 4, number of chip selects (1..8).
REQ-002 SHALL provide parameter CLK_DIV, default 4, SCLK half-period in clk cycles; values <4 SHALL cause an elaboration error.
REQ-003 SHALL provide parameters CS_SETUP, CS_HOLD and CS_IDLE, each default 4, minimum 4, giving CS-low-to-first-SCLK, last-SCLK-to-CS-high and CS-high gap, in clk cycles.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: transaction request, sampled only in IDLE.
REQ-007 SHALL have port rd, input, 1: 1 = read, 0 = write.
REQ-008 SHALL have port slave_sel, input, 3: target slave index, also sent as slave ID.
REQ-009 SHALL have port addr, input, 8: slave RAM word address.
REQ-010 SHALL have port wdata, input, 16: write data.
REQ-011 SHALL have port busy, output, 1: high from accept until done.
REQ-012 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port err, output, 1: valid with done; 1 = slave_sel out of range.
REQ-014 SHALL have port rdata, output, 16: last read data.
REQ-015 SHALL have ports sclk (output, 1), mosi (output, 1), miso (input, 1) and cs_n (output, N_SLAVES, active-low, one-hot-low).

Function
REQ-016 SHALL accept start only when busy=0; rd, slave_sel, addr and wdata SHALL be latched in the accept cycle; start while busy SHALL be ignored.
REQ-017 SHALL send a 32-bit frame, MSB first: command word {2'b00, slave_sel[2:0], addr[7:0], 1'b0, rd, 1'b0}, then data word (wdata for writes, 16'h0000 for reads).
REQ-018 SHALL use states IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
REQ-019 SETUP: cs_n[slave_sel] low, sclk 0, mosi = frame bit 31; duration CS_SETUP cycles.
REQ-020 SHIFT: SPI mode 0; sclk idle 0, toggling every CLK_DIV cycles for exactly 32 rising and 32 falling edges.
REQ-021 mosi SHALL change only in the cycle sclk is driven low; it SHALL be constant across each rising edge.
REQ-022 On each of rising edges 17..32, miso SHALL be sampled into a shift register in the cycle sclk is driven high; rising edges 1..16 SHALL be ignored.
REQ-023 HOLD SHALL begin after the 32nd falling edge, keep cs_n low with sclk 0 and mosi 0 for CS_HOLD cycles, and then drive cs_n all-ones.
REQ-024 GAP SHALL keep cs_n all-ones for CS_IDLE cycles, then pulse done for 1 cycle and drop busy in that same cycle; the next start SHALL be accepted in the cycle after done.
REQ-025 For reads, rdata SHALL update with the captured word in the done cycle; for writes, rdata SHALL be unchanged.
REQ-026 Accept to done SHALL be exactly CS_SETUP + 64*CLK_DIV + CS_HOLD + CS_IDLE + 1 cycles.
REQ-027 If slave_sel >= N_SLAVES: no cs_n asserted, no sclk activity, done=1 and err=1 in the cycle after accept; err SHALL be 0 on all other done pulses.
REQ-028 At most one cs_n bit SHALL be low at any time.
REQ-029 Outside SETUP/SHIFT/HOLD, sclk and mosi SHALL be 0.

Reset
REQ-030 rst_n low SHALL immediately (asynchronously) force cs_n all-ones, sclk 0, mosi 0, busy 0, done 0, err 0, rdata 0, and state IDLE, including mid-transfer.
REQ-031 After rst_n rises, start SHALL be accepted on the first clk edge at which it is sampled high.

Verification
REQ-032 Write slave 0, addr 0x12, wdata 0xA5C3 -> MOSI frame 0x0090A5C3, cs_n=4'b1110 during transfer, slave RAM[0x12]=0xA5C3, done after 269 cycles (defaults).
REQ-033 Read slave 0, addr 0x12 after REQ-032 -> command 0x0092, rdata=0xA5C3 in the done cycle, err=0.
REQ-034 Write slave 2, addr 0xFF, wdata 0x0001 -> command 0x17F8, only cs_n[2] low; rdata unchanged.
REQ-035 slave_sel=5 with N_SLAVES=4 -> cs_n stays 4'hF, sclk stays 0, done=err=1 one cycle after accept.
REQ-036 start pulsed while busy, and rst_n asserted at SCLK edge 10 -> second start ignored; reset immediately gives cs_n=4'hF, busy=0, rdata=0; a new write then completes correctly.
